// File: rtl/smart_appliance_scheduler_if.sv
// Hub-side request/response handshake for the appliance scheduler.
interface smart_appliance_scheduler_if #(
    parameter int unsigned DUR_W = 16
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       req_dev;
    logic             req_on;
    logic [DUR_W-1:0] req_duration;
    logic             resp_valid;
    logic [2:0]       resp_code;

    modport master (
        output req_valid, req_dev, req_on, req_duration,
        input  req_ready, resp_valid, resp_code
    );

    modport slave (
        input  req_valid, req_dev, req_on, req_duration,
        output req_ready, resp_valid, resp_code
    );
endinterface

// File: rtl/smart_appliance_scheduler.sv
// Issues budget-checked on/off commands to five appliances, confirms them against
// the status lines with a timeout, and auto-switches devices off on run-timer expiry.
module smart_appliance_scheduler #(
    parameter int unsigned DUR_W       = 16,
    parameter int unsigned MAX_ON      = 3,
    parameter int unsigned ACK_TIMEOUT = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       tick_en,
    smart_appliance_scheduler_if.slave bus,
    input  logic                       fault_clr,
    output logic [4:0]                 fault,
    output logic                       fridge_cmd,
    output logic                       oven_cmd,
    output logic                       coffee_maker_cmd,
    output logic                       washer_cmd,
    output logic                       dishwasher_cmd,
    input  logic                       fridge_status,
    input  logic                       oven_status,
    input  logic                       coffee_maker_status,
    input  logic                       washer_status,
    input  logic                       dishwasher_status
);
    localparam int unsigned CNT_W = $clog2(ACK_TIMEOUT);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CHECK    = 2'd1;
    localparam logic [1:0] S_WAIT_ACK = 2'd2;
    localparam logic [1:0] S_RESP     = 2'd3;

    logic [1:0]       state;
    logic [4:0]       cmd;
    logic [4:0]       status;
    logic [DUR_W-1:0] timer [5];
    logic [CNT_W-1:0] ack_cnt;
    logic [2:0]       dev_q;
    logic             on_q;
    logic [DUR_W-1:0] dur_q;
    logic [2:0]       resp_code_q;
    int unsigned      on_count;

    assign status = {dishwasher_status, washer_status, coffee_maker_status,
                     oven_status, fridge_status};

    assign fridge_cmd       = cmd[0];
    assign oven_cmd         = cmd[1];
    assign coffee_maker_cmd = cmd[2];
    assign washer_cmd       = cmd[3];
    assign dishwasher_cmd   = cmd[4];

    assign bus.req_ready  = (state == S_IDLE);
    assign bus.resp_valid = (state == S_RESP);
    assign bus.resp_code  = resp_code_q;

    always_comb begin
        on_count = 0;
        for (int unsigned i = 0; i < 5; i++) begin
            on_count = on_count + {31'd0, cmd[i]};
        end
    end

    // Later non-blocking writes override earlier ones: CHECK/timeout updates
    // beat the tick-driven timer update, and a timeout set beats fault_clr.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            cmd         <= '0;
            fault       <= '0;
            ack_cnt     <= '0;
            dev_q       <= '0;
            on_q        <= 1'b0;
            dur_q       <= '0;
            resp_code_q <= '0;
            for (int unsigned i = 0; i < 5; i++) begin
                timer[i] <= '0;
            end
        end else begin
            if (tick_en) begin
                for (int unsigned i = 0; i < 5; i++) begin
                    if (timer[i] != '0) begin
                        timer[i] <= timer[i] - DUR_W'(1);
                        if (timer[i] == DUR_W'(1)) cmd[i] <= 1'b0;
                    end
                end
            end

            if (fault_clr) fault <= '0;

            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        dev_q <= bus.req_dev;
                        on_q  <= bus.req_on;
                        dur_q <= bus.req_duration;
                        state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    if (dev_q > 3'd4) begin
                        resp_code_q <= 3'd1;
                        state       <= S_RESP;
                    end else if (fault[dev_q]) begin
                        resp_code_q <= 3'd4;
                        state       <= S_RESP;
                    end else if (on_q && !cmd[dev_q] && on_count >= MAX_ON) begin
                        resp_code_q <= 3'd2;
                        state       <= S_RESP;
                    end else begin
                        cmd[dev_q]   <= on_q;
                        timer[dev_q] <= on_q ? dur_q : '0;
                        ack_cnt      <= '0;
                        state        <= S_WAIT_ACK;
                    end
                end
                S_WAIT_ACK: begin
                    if (status[dev_q] == cmd[dev_q]) begin
                        resp_code_q <= 3'd0;
                        state       <= S_RESP;
                    end else if (ack_cnt == CNT_W'(ACK_TIMEOUT - 1)) begin
                        cmd[dev_q]   <= 1'b0;
                        timer[dev_q] <= '0;
                        fault[dev_q] <= 1'b1;
                        resp_code_q  <= 3'd3;
                        state        <= S_RESP;
                    end else begin
                        ack_cnt <= ack_cnt + CNT_W'(1);
                    end
                end
                S_RESP:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_smart_appliance_scheduler.sv
// Directed scenarios followed by randomized requests/ticks checked against a
// per-device on/remaining-time/fault model of the scheduler.
module tb_smart_appliance_scheduler;
    localparam int unsigned DUR_W       = 16;
    localparam int unsigned ACK_TIMEOUT = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_en = 1'b0;
    logic       fault_clr = 1'b0;
    logic [4:0] fault;
    wire  [4:0] cmd_vec;
    logic [4:0] status_q = '0;
    logic [4:0] stuck = '0;

    int n_assert = 0;
    int n_fail   = 0;

    logic [4:0] m_on;
    logic [4:0] m_fault;
    int         m_rem [5];

    smart_appliance_scheduler_if #(.DUR_W(DUR_W)) bus ();

    smart_appliance_scheduler #(
        .DUR_W(DUR_W), .MAX_ON(3), .ACK_TIMEOUT(ACK_TIMEOUT)
    ) dut (
        .clk(clk), .rst(rst), .tick_en(tick_en), .bus(bus),
        .fault_clr(fault_clr), .fault(fault),
        .fridge_cmd(cmd_vec[0]), .oven_cmd(cmd_vec[1]), .coffee_maker_cmd(cmd_vec[2]),
        .washer_cmd(cmd_vec[3]), .dishwasher_cmd(cmd_vec[4]),
        .fridge_status(status_q[0]), .oven_status(status_q[1]),
        .coffee_maker_status(status_q[2]), .washer_status(status_q[3]),
        .dishwasher_status(status_q[4])
    );

    always #5 clk = ~clk;

    // Appliances echo their command one cycle later unless held stuck-off.
    always @(posedge clk) status_q <= cmd_vec & ~stuck;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_resp(output logic [2:0] code, output int lat);
        bit got;
        got = 0; lat = 0; code = 3'd7;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bus.resp_valid) begin
                got = 1; lat = k; code = bus.resp_code;
                break;
            end
        end
        check("resp_seen", {31'd0, got}, 1);
        @(posedge clk); #1;
        check("resp_one_cycle", {31'd0, bus.resp_valid}, 0);
    endtask

    task automatic do_req(input logic [2:0] dev, input logic on, input logic [DUR_W-1:0] dur,
                          output logic [2:0] code, output int lat);
        int n;
        bus.req_valid = 1'b1; bus.req_dev = dev; bus.req_on = on; bus.req_duration = dur;
        n = 0;
        while (!bus.req_ready && n < 20) begin @(posedge clk); #1; n++; end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        wait_resp(code, lat);
    endtask

    task automatic tick();
        tick_en = 1'b1;
        @(posedge clk); #1;
        tick_en = 1'b0;
    endtask

    task automatic model_tick();
        for (int i = 0; i < 5; i++) begin
            if (m_rem[i] > 0) begin
                m_rem[i]--;
                if (m_rem[i] == 0) m_on[i] = 1'b0;
            end
        end
    endtask

    function automatic logic [2:0] model_req(input int dev, input bit on, input int dur);
        if (dev > 4) return 3'd1;
        if (m_fault[dev]) return 3'd4;
        if (on && !m_on[dev] && $countones(m_on) >= 3) return 3'd2;
        if (on && stuck[dev]) begin
            m_on[dev] = 1'b0; m_rem[dev] = 0; m_fault[dev] = 1'b1;
            return 3'd3;
        end
        m_on[dev]  = on;
        m_rem[dev] = on ? dur : 0;
        return 3'd0;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        logic [2:0] code;
        logic [2:0] exp_code;
        int         lat;
        bit         seen;

        bus.req_valid = 1'b0; bus.req_dev = '0; bus.req_on = 1'b0; bus.req_duration = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_cmd", {27'd0, cmd_vec}, 0);
        check("rst_fault", {27'd0, fault}, 0);
        check("rst_resp_valid", {31'd0, bus.resp_valid}, 0);
        check("rst_resp_code", {29'd0, bus.resp_code}, 0);
        check("rst_req_ready", {31'd0, bus.req_ready}, 1);
        rst = 1'b0;
        @(posedge clk); #1;

        // Oven on indefinitely
        do_req(3'd1, 1'b1, 16'd0, code, lat);
        check("t1_code", {29'd0, code}, 0);
        check("t1_latency", lat, 3);
        check("t1_cmd", {27'd0, cmd_vec}, 5'b00010);
        repeat (3) tick();
        check("t1_still_on", {27'd0, cmd_vec}, 5'b00010);

        // Coffee maker runs for three ticks
        do_req(3'd2, 1'b1, 16'd3, code, lat);
        check("t2_code", {29'd0, code}, 0);
        tick(); tick();
        check("t2_after_2_ticks", {31'd0, cmd_vec[2]}, 1);
        tick();
        check("t2_after_3_ticks", {31'd0, cmd_vec[2]}, 0);

        // Power budget
        do_req(3'd0, 1'b1, 16'd0, code, lat);
        check("t3_fridge_code", {29'd0, code}, 0);
        do_req(3'd3, 1'b1, 16'd0, code, lat);
        check("t3_washer_code", {29'd0, code}, 0);
        check("t3_three_on", {27'd0, cmd_vec}, 5'b01011);
        do_req(3'd4, 1'b1, 16'd0, code, lat);
        check("t3_budget_code", {29'd0, code}, 2);
        check("t3_dishwasher_off", {31'd0, cmd_vec[4]}, 0);
        do_req(3'd1, 1'b0, 16'd0, code, lat);
        check("t3_oven_off_code", {29'd0, code}, 0);
        check("t3_oven_off_cmd", {27'd0, cmd_vec}, 5'b01001);
        do_req(3'd4, 1'b1, 16'd0, code, lat);
        check("t3_retry_code", {29'd0, code}, 0);
        check("t3_retry_cmd", {27'd0, cmd_vec}, 5'b11001);

        // Ack timeout and fault handling on the washer
        do_req(3'd3, 1'b0, 16'd0, code, lat);
        check("t4_washer_off_code", {29'd0, code}, 0);
        stuck[3] = 1'b1;
        @(posedge clk); #1;
        do_req(3'd3, 1'b1, 16'd0, code, lat);
        check("t4_timeout_code", {29'd0, code}, 3);
        check("t4_timeout_latency", lat, ACK_TIMEOUT + 1);
        check("t4_washer_cmd", {31'd0, cmd_vec[3]}, 0);
        check("t4_fault", {27'd0, fault}, 5'b01000);
        do_req(3'd3, 1'b1, 16'd0, code, lat);
        check("t4_faulted_code", {29'd0, code}, 4);
        check("t4_faulted_cmd", {31'd0, cmd_vec[3]}, 0);
        fault_clr = 1'b1;
        @(posedge clk); #1;
        fault_clr = 1'b0;
        check("t4_fault_cleared", {27'd0, fault}, 0);
        stuck[3] = 1'b0;
        @(posedge clk); #1;
        do_req(3'd3, 1'b1, 16'd0, code, lat);
        check("t4_retry_code", {29'd0, code}, 0);
        check("t4_retry_cmd", {27'd0, cmd_vec}, 5'b11001);

        // Invalid device
        do_req(3'd6, 1'b1, 16'd2, code, lat);
        check("t5_bad_dev_code", {29'd0, code}, 1);
        check("t5_bad_dev_cmd", {27'd0, cmd_vec}, 5'b11001);

        // Timer expiry colliding with a CHECK reload of the same device
        do_req(3'd3, 1'b1, 16'd1, code, lat);
        check("t5_reload1_code", {29'd0, code}, 0);
        bus.req_valid = 1'b1; bus.req_dev = 3'd3; bus.req_on = 1'b1; bus.req_duration = 16'd5;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        tick_en = 1'b1;
        @(posedge clk); #1;
        tick_en = 1'b0;
        wait_resp(code, lat);
        check("t5_collide_code", {29'd0, code}, 0);
        check("t5_collide_cmd", {31'd0, cmd_vec[3]}, 1);
        repeat (4) tick();
        check("t5_after_4_ticks", {31'd0, cmd_vec[3]}, 1);
        tick();
        check("t5_after_5_ticks", {27'd0, cmd_vec}, 5'b10001);

        // Reset during WAIT_ACK
        bus.req_valid = 1'b1; bus.req_dev = 3'd2; bus.req_on = 1'b1; bus.req_duration = 16'd0;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        check("t6_pre_rst_cmd", {31'd0, cmd_vec[2]}, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("t6_cmd_cleared", {27'd0, cmd_vec}, 0);
        check("t6_req_ready", {31'd0, bus.req_ready}, 1);
        seen = 1'b0;
        for (int k = 0; k < 6; k++) begin
            if (bus.resp_valid) seen = 1'b1;
            @(posedge clk); #1;
        end
        check("t6_no_resp", {31'd0, seen}, 0);

        // Randomized phase against the model
        m_on = '0; m_fault = '0;
        for (int i = 0; i < 5; i++) m_rem[i] = 0;
        for (int it = 0; it < 100; it++) begin
            int unsigned sel;
            sel = $urandom_range(0, 9);
            if (sel <= 5) begin
                logic [2:0] dev;
                bit         on;
                int         dur;
                dev = ($urandom_range(0, 11) > 9) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
                on  = ($urandom_range(0, 2) != 0);
                dur = $urandom_range(0, 4);
                exp_code = model_req(int'(dev), on, dur);
                do_req(dev, on, DUR_W'(dur), code, lat);
                check("rand_code", {29'd0, code}, {29'd0, exp_code});
            end else if (sel <= 7) begin
                repeat ($urandom_range(1, 3)) begin
                    tick();
                    model_tick();
                end
            end else if (sel == 8) begin
                fault_clr = 1'b1;
                @(posedge clk); #1;
                fault_clr = 1'b0;
                m_fault = '0;
            end else begin
                stuck[$urandom_range(0, 4)] ^= 1'b1;
                @(posedge clk); #1;
            end
            check("rand_cmd", {27'd0, cmd_vec}, {27'd0, m_on});
            check("rand_fault", {27'd0, fault}, {27'd0, m_fault});
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
